// File: rtl/spi_wb_arbiter.sv
// rtl/spi_wb_arbiter.sv - two-requester Wishbone arbiter in front of the shared SPI master
module spi_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADR_W          = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             m0_cyc,
   input  logic             m0_stb,
   input  logic             m0_we,
   input  logic             m0_lock,
   input  logic [ADR_W-1:0] m0_adr,
   input  logic [31:0]      m0_dat_w,
   input  logic [3:0]       m0_sel,
   output logic             m0_ack,
   output logic             m0_err,
   output logic [31:0]      m0_dat_r,
   input  logic             m1_cyc,
   input  logic             m1_stb,
   input  logic             m1_we,
   input  logic             m1_lock,
   input  logic [ADR_W-1:0] m1_adr,
   input  logic [31:0]      m1_dat_w,
   input  logic [3:0]       m1_sel,
   output logic             m1_ack,
   output logic             m1_err,
   output logic [31:0]      m1_dat_r,
   output logic             s_cyc,
   output logic             s_stb,
   output logic             s_we,
   output logic [ADR_W-1:0] s_adr,
   output logic [31:0]      s_dat_w,
   output logic [3:0]       s_sel,
   input  logic             s_ack,
   input  logic             s_err,
   input  logic [31:0]      s_dat_r,
   output logic [1:0]       gnt
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        last_gnt;   // 1 = m1 was granted last, so m0 wins the next tie
   logic [15:0] to_cnt;

   logic       own0, own1;
   logic       o_cyc, o_stb, o_lock;
   logic       to_hit, timeout;
   logic       req0, req1;

   assign req0 = m0_cyc & m0_stb;
   assign req1 = m1_cyc & m1_stb;

   // Owner selection and combinational routing; reset masks everything so an
   // abandoned transaction never produces a response.
   always_comb begin
      own0   = (state == OWN0) && !reset;
      own1   = (state == OWN1) && !reset;
      o_cyc  = own0 ? m0_cyc  : (own1 ? m1_cyc  : 1'b0);
      o_stb  = own0 ? m0_stb  : (own1 ? m1_stb  : 1'b0);
      o_lock = own0 ? m0_lock : (own1 ? m1_lock : 1'b0);
      // Forcing the slave strobe low depends only on the counter, not on
      // s_ack, so a combinational slave cannot form a loop through us.
      to_hit  = (own0 | own1) & o_stb & (to_cnt == TO_LAST);
      timeout = to_hit & !s_ack & !s_err;
      s_cyc   = o_cyc & !to_hit;
      s_stb   = o_stb & !to_hit;
      s_we    = own0 ? m0_we    : (own1 ? m1_we    : 1'b0);
      s_adr   = own0 ? m0_adr   : (own1 ? m1_adr   : '0);
      s_dat_w = own0 ? m0_dat_w : (own1 ? m1_dat_w : 32'h0);
      s_sel   = own0 ? m0_sel   : (own1 ? m1_sel   : 4'h0);
      m0_ack   = own0 & s_ack;
      m1_ack   = own1 & s_ack;
      m0_err   = own0 & (s_err | timeout);
      m1_err   = own1 & (s_err | timeout);
      m0_dat_r = own0 ? s_dat_r : 32'h0;
      m1_dat_r = own1 ? s_dat_r : 32'h0;
   end

   // Ownership FSM with round-robin tie break and strobe timeout counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= 2'b00;
         last_gnt <= 1'b1;
         to_cnt   <= 16'h0;
      end else begin
         case (state)
            IDLE: begin
               to_cnt <= 16'h0;
               if (req0 && (!req1 || last_gnt)) begin
                  state    <= OWN0;
                  gnt      <= 2'b01;
                  last_gnt <= 1'b0;
               end else if (req1) begin
                  state    <= OWN1;
                  gnt      <= 2'b10;
                  last_gnt <= 1'b1;
               end
            end
            OWN0, OWN1: begin
               if (!o_cyc && !o_lock) begin
                  state  <= IDLE;
                  gnt    <= 2'b00;
                  to_cnt <= 16'h0;
               end else if (!o_stb || s_ack || s_err || timeout) begin
                  to_cnt <= 16'h0;
               end else begin
                  to_cnt <= to_cnt + 16'h1;
               end
            end
            default: begin
               state  <= IDLE;
               gnt    <= 2'b00;
               to_cnt <= 16'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// tb/tb_spi_wb_arbiter.sv - scoreboard bench for spi_wb_arbiter
module tb_spi_wb_arbiter;

   localparam int ADR_W = 5;

   logic             clock = 1'b0;
   logic             reset;
   logic             m0_cyc, m0_stb, m0_we, m0_lock;
   logic [ADR_W-1:0] m0_adr;
   logic [31:0]      m0_dat_w;
   logic [3:0]       m0_sel;
   logic             m0_ack, m0_err;
   logic [31:0]      m0_dat_r;
   logic             m1_cyc, m1_stb, m1_we, m1_lock;
   logic [ADR_W-1:0] m1_adr;
   logic [31:0]      m1_dat_w;
   logic [3:0]       m1_sel;
   logic             m1_ack, m1_err;
   logic [31:0]      m1_dat_r;
   logic             s_cyc, s_stb, s_we;
   logic [ADR_W-1:0] s_adr;
   logic [31:0]      s_dat_w;
   logic [3:0]       s_sel;
   logic             s_ack, s_err;
   logic [31:0]      s_dat_r;
   logic [1:0]       gnt;

   int n_checks = 0;
   int n_errors = 0;
   int n_ack1   = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic        qe1[$];

   spi_wb_arbiter #(.TIMEOUT_CYCLES(8), .ADR_W(ADR_W)) dut (
      .clock(clock), .reset(reset),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_lock(m0_lock),
      .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_r(m0_dat_r),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_lock(m1_lock),
      .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_r(m1_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_sel(s_sel),
      .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
      .gnt(gnt)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Response monitor: every ack/err must match an expectation in the queues.
   always @(negedge clock) begin
      if (m0_ack) begin
         if (q0.size() == 0) check_eq("m0_unexpected_ack", 1, 0);
         else check_eq("m0_dat_r", m0_dat_r, q0.pop_front());
      end
      if (m1_ack) begin
         n_ack1++;
         if (q1.size() == 0) check_eq("m1_unexpected_ack", 1, 0);
         else check_eq("m1_dat_r", m1_dat_r, q1.pop_front());
      end
      if (m0_err) check_eq("m0_unexpected_err", 1, 0);
      if (m1_err) begin
         if (qe1.size() == 0) check_eq("m1_unexpected_err", 1, 0);
         else check_eq("m1_err_expected", {31'h0, qe1.pop_front()}, 1);
      end
   end

   logic [ADR_W-1:0] wr_adr [5];
   int ack_before;

   initial begin
      wr_adr[0] = 5'h04; wr_adr[1] = 5'h14; wr_adr[2] = 5'h18;
      wr_adr[3] = 5'h10; wr_adr[4] = 5'h10;
      reset = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; m0_adr = '0; m0_dat_w = 0; m0_sel = 0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_lock = 0; m1_adr = '0; m1_dat_w = 0; m1_sel = 0;
      s_ack = 0; s_err = 0; s_dat_r = 0;
      repeat (3) tick;
      reset = 1'b0;

      // reset state
      check_eq("rst_gnt", {30'h0, gnt}, 0);
      check_eq("rst_s_cyc", {31'h0, s_cyc}, 0);
      check_eq("rst_s_stb", {31'h0, s_stb}, 0);
      check_eq("rst_s_adr", {27'h0, s_adr}, 0);

      // m1 alone reads 0x10, slave acks 3 cycles later
      ack_before = n_ack1;
      m1_cyc = 1; m1_stb = 1; m1_adr = 5'h10; m1_sel = 4'hf;
      #2;
      check_eq("t1_req_cycle_gnt", {30'h0, gnt}, 0);
      check_eq("t1_req_cycle_s_stb", {31'h0, s_stb}, 0);
      tick;
      check_eq("t1_gnt", {30'h0, gnt}, 2'b10);
      check_eq("t1_s_adr", {27'h0, s_adr}, 5'h10);
      check_eq("t1_s_stb", {31'h0, s_stb}, 1);
      tick; tick;
      s_ack = 1; s_dat_r = 32'h0000_0100; q1.push_back(32'h0000_0100);
      #1;
      check_eq("t1_m1_ack", {31'h0, m1_ack}, 1);
      check_eq("t1_m0_ack", {31'h0, m0_ack}, 0);
      check_eq("t1_m0_dat_r", m0_dat_r, 0);
      tick;
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      tick; tick;
      check_eq("t1_ack_count", n_ack1 - ack_before, 1);
      check_eq("t1_idle_gnt", {30'h0, gnt}, 0);

      // simultaneous requests right after reset: m0 first, dead cycle, then m1
      reset = 1; tick; reset = 0;
      m0_cyc = 1; m0_stb = 1; m0_adr = 5'h01;
      m1_cyc = 1; m1_stb = 1; m1_adr = 5'h02;
      tick;
      check_eq("t2_gnt_m0", {30'h0, gnt}, 2'b01);
      check_eq("t2_s_adr", {27'h0, s_adr}, 5'h01);
      s_ack = 1; s_dat_r = 32'hA0; q0.push_back(32'hA0);
      tick;
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      check_eq("t2_gnt_hold", {30'h0, gnt}, 2'b01);
      tick;
      check_eq("t2_dead_cycle", {30'h0, gnt}, 0);
      check_eq("t2_dead_s_stb", {31'h0, s_stb}, 0);
      tick;
      check_eq("t2_gnt_m1", {30'h0, gnt}, 2'b10);
      s_ack = 1; s_dat_r = 32'hB1; q1.push_back(32'hB1);
      tick;
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      tick; tick;

      // m0 locked across five writes while m1 requests throughout
      m0_lock = 1; m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = wr_adr[0];
      m1_cyc = 1; m1_stb = 1; m1_adr = 5'h03;
      tick;
      for (int i = 0; i < 5; i++) begin
         m0_cyc = 1; m0_stb = 1; m0_adr = wr_adr[i]; m0_dat_w = 32'h100 + i;
         #1;
         check_eq($sformatf("t3_gnt_%0d", i), {30'h0, gnt}, 2'b01);
         check_eq($sformatf("t3_s_adr_%0d", i), {27'h0, s_adr}, {27'h0, wr_adr[i]});
         check_eq($sformatf("t3_s_dat_w_%0d", i), s_dat_w, 32'h100 + i);
         tick;
         s_ack = 1; s_dat_r = 32'hC0 + i; q0.push_back(32'hC0 + i);
         tick;
         s_ack = 0; m0_stb = 0; m0_cyc = 0;
         tick;
         check_eq($sformatf("t3_locked_%0d", i), {30'h0, gnt}, 2'b01);
      end
      m0_lock = 0; m0_we = 0;
      tick;
      check_eq("t3_release_idle", {30'h0, gnt}, 0);
      tick;
      check_eq("t3_gnt_m1", {30'h0, gnt}, 2'b10);
      s_ack = 1; s_dat_r = 32'hD1; q1.push_back(32'hD1);
      tick;
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      tick; tick;

      // m1 never acked: timeout on 8th stb cycle, restart, then ack wins on 3rd
      m1_cyc = 1; m1_stb = 1; m1_adr = 5'h08;
      tick;
      for (int c = 1; c <= 24; c++) begin
         if (c == 8 || c == 16) begin
            qe1.push_back(1'b1);
            #1;
            check_eq($sformatf("t4_err_c%0d", c), {31'h0, m1_err}, 1);
            check_eq($sformatf("t4_s_stb_c%0d", c), {31'h0, s_stb}, 0);
            check_eq($sformatf("t4_s_cyc_c%0d", c), {31'h0, s_cyc}, 0);
         end else if (c == 24) begin
            s_ack = 1; s_dat_r = 32'hE1; q1.push_back(32'hE1);
            #1;
            check_eq("t5_ack_wins", {31'h0, m1_ack}, 1);
            check_eq("t5_no_err", {31'h0, m1_err}, 0);
         end else if (c == 7 || c == 9) begin
            #1;
            check_eq($sformatf("t4_s_stb_c%0d", c), {31'h0, s_stb}, 1);
         end
         tick;
      end
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      tick; tick;

      // reset while m0 has a pending strobe
      m0_cyc = 1; m0_stb = 1; m0_adr = 5'h0A;
      tick;
      check_eq("t6_gnt_m0", {30'h0, gnt}, 2'b01);
      check_eq("t6_s_stb", {31'h0, s_stb}, 1);
      reset = 1;
      tick;
      check_eq("t6_gnt_after_rst", {30'h0, gnt}, 0);
      check_eq("t6_s_cyc", {31'h0, s_cyc}, 0);
      check_eq("t6_s_stb_rst", {31'h0, s_stb}, 0);
      check_eq("t6_s_adr", {27'h0, s_adr}, 0);
      check_eq("t6_m0_ack", {31'h0, m0_ack}, 0);
      check_eq("t6_m0_err", {31'h0, m0_err}, 0);
      reset = 0; m0_cyc = 0; m0_stb = 0;
      tick; tick;

      check_eq("q0_drained", q0.size(), 0);
      check_eq("q1_drained", q1.size(), 0);
      check_eq("qe1_drained", qe1.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
